// File: rtl/gemm_pkg.sv
// Shared types and sizing helpers for the GEMM operand loader.
// GEMM_LOADER_BIAS_EN adds the bias section to the frame.
package gemm_pkg;

   typedef enum logic [1:0] {
      ST_LOAD_A,
      ST_LOAD_B,
      ST_LOAD_BIAS,
      ST_RUN
   } state_e;

   typedef logic signed [7:0] elem_a_t;
   typedef logic signed [7:0] elem_b_t;
   typedef logic signed [7:0] elem_bias_t;

   function automatic int a_len(input int m, input int k);
      return m * k;
   endfunction

   function automatic int b_len(input int k, input int n);
      return k * n;
   endfunction

   function automatic int bias_len(input int n);
      return n;
   endfunction

   function automatic int frame_len(input int m, input int n, input int k);
`ifdef GEMM_LOADER_BIAS_EN
      return a_len(m, k) + b_len(k, n) + bias_len(n);
`else
      return a_len(m, k) + b_len(k, n);
`endif
   endfunction

   function automatic int max_section_len(input int m, input int n, input int k);
      int mx;
      mx = a_len(m, k);
      if (b_len(k, n) > mx) mx = b_len(k, n);
      if (bias_len(n) > mx) mx = bias_len(n);
      return mx;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/gemm_run_seq.sv
// Bit-serial run sequencer: one pulse on start gives M*DATA_WIDTH_A cycles
// of gen_done, a row strobe at the end of each row, then a done strobe.
module gemm_run_seq
   import gemm_pkg::*;
#(
   parameter int M            = 2,
   parameter int DATA_WIDTH_A = 8,
   parameter int RIW          = clog2_min1(M)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           gen_done,
   output logic           row_valid,
   output logic [RIW-1:0] row_idx,
   output logic           done,
   output logic           last_cycle
);

   localparam int TW = clog2_min1(DATA_WIDTH_A);
   localparam logic [TW-1:0]  T_LAST = TW'(DATA_WIDTH_A - 1);
   localparam logic [RIW-1:0] M_LAST = RIW'(M - 1);

   logic [TW-1:0]  t_q, t_d;
   logic [RIW-1:0] m_q, m_d;
   logic           gen_q, gen_d;
   logic           done_q, done_d;

   always_comb begin
      t_d    = t_q;
      m_d    = m_q;
      gen_d  = gen_q;
      done_d = 1'b0;
      if (start) begin
         gen_d = 1'b1;
         t_d   = '0;
         m_d   = '0;
      end else if (gen_q) begin
         if (t_q == T_LAST) begin
            t_d = '0;
            if (m_q == M_LAST) begin
               m_d    = '0;
               gen_d  = 1'b0;
               done_d = 1'b1;
            end else begin
               m_d = m_q + 1'b1;
            end
         end else begin
            t_d = t_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_q    <= '0;
         m_q    <= '0;
         gen_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         t_q    <= t_d;
         m_q    <= m_d;
         gen_q  <= gen_d;
         done_q <= done_d;
      end
   end

   assign gen_done   = gen_q;
   assign row_valid  = gen_q && (t_q == T_LAST);
   assign row_idx    = m_q;
   assign done       = done_q;
   assign last_cycle = row_valid && (m_q == M_LAST);

endmodule

// File: rtl/gemm_operand_loader.sv
// Loads one A/B(/bias) operand frame from a byte stream, then runs the GEMM.
// Define GEMM_LOADER_BIAS_EN to include the bias section and bias_en.
module gemm_operand_loader
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH_A    = 8,
   parameter int DATA_WIDTH_B    = 8,
   parameter int DATA_WIDTH_bias = 8,
   parameter int WORD_WIDTH      = 8,
   parameter int M               = 2,
   parameter int N               = 4,
   parameter int K               = 4,
   localparam int RIW            = clog2_min1(M)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      s_valid,
   output logic                                      s_ready,
   input  logic [WORD_WIDTH-1:0]                     s_data,
   input  logic                                      s_last,
   output logic [M-1:0][K-1:0][DATA_WIDTH_A-1:0]     A,
   output logic [K-1:0][N-1:0][DATA_WIDTH_B-1:0]     B,
   output logic [N-1:0][DATA_WIDTH_bias-1:0]         bias,
   output logic                                      bias_en,
   output logic                                      gen_done,
   output logic                                      row_valid,
   output logic [RIW-1:0]                            row_idx,
   output logic                                      done,
   output logic                                      error
);

   localparam int A_LEN = a_len(M, K);
   localparam int B_LEN = b_len(K, N);
   localparam int CW    = clog2_min1(max_section_len(M, N, K));

   if (WORD_WIDTH < DATA_WIDTH_A || WORD_WIDTH < DATA_WIDTH_B ||
       WORD_WIDTH < DATA_WIDTH_bias) begin : g_width_check
      $error("WORD_WIDTH must be at least every element width");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, sec_last;
   logic          err_q, err_d;
   logic          accept, sec_final, last_sec, frame_final, start, run_last;
   logic [M-1:0][K-1:0][DATA_WIDTH_A-1:0] a_q, a_d;
   logic [K-1:0][N-1:0][DATA_WIDTH_B-1:0] b_q, b_d;

   assign s_ready = rst && (state_q != ST_RUN);
   assign accept  = s_valid && s_ready;

   // Which word closes the current section, and whether it also closes the frame.
   always_comb begin
      sec_last = CW'(A_LEN - 1);
      last_sec = 1'b0;
      case (state_q)
         ST_LOAD_B: begin
            sec_last = CW'(B_LEN - 1);
`ifndef GEMM_LOADER_BIAS_EN
            last_sec = 1'b1;
`endif
         end
`ifdef GEMM_LOADER_BIAS_EN
         ST_LOAD_BIAS: begin
            sec_last = CW'(bias_len(N) - 1);
            last_sec = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign sec_final   = (cnt_q == sec_last);
   assign frame_final = sec_final && last_sec;

   // A framing error abandons the frame; error set takes priority over the first-word clear.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      start   = 1'b0;
      if (state_q == ST_RUN) begin
         if (run_last) state_d = ST_LOAD_A;
      end else if (accept) begin
         if (state_q == ST_LOAD_A && cnt_q == '0) err_d = 1'b0;
         if (s_last != frame_final) begin
            err_d   = 1'b1;
            state_d = ST_LOAD_A;
            cnt_d   = '0;
         end else if (frame_final) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            start   = 1'b1;
         end else if (sec_final) begin
            state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_LOAD_BIAS;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      for (int r = 0; r < M; r++)
         for (int c = 0; c < K; c++)
            if (accept && state_q == ST_LOAD_A && cnt_q == CW'(r * K + c))
               a_d[r][c] = s_data[DATA_WIDTH_A-1:0];
      for (int r = 0; r < K; r++)
         for (int c = 0; c < N; c++)
            if (accept && state_q == ST_LOAD_B && cnt_q == CW'(r * N + c))
               b_d[r][c] = s_data[DATA_WIDTH_B-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOAD_A;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

`ifdef GEMM_LOADER_BIAS_EN
   logic [N-1:0][DATA_WIDTH_bias-1:0] bias_q, bias_d;

   always_comb begin
      bias_d = bias_q;
      for (int i = 0; i < N; i++)
         if (accept && state_q == ST_LOAD_BIAS && cnt_q == CW'(i))
            bias_d[i] = s_data[DATA_WIDTH_bias-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bias_q <= '0;
      else      bias_q <= bias_d;
   end

   assign bias    = bias_q;
   assign bias_en = (state_q == ST_RUN);
`else
   assign bias    = '0;
   assign bias_en = 1'b0;
`endif

   gemm_run_seq #(
      .M            (M),
      .DATA_WIDTH_A (DATA_WIDTH_A),
      .RIW          (RIW)
   ) u_run_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .gen_done   (gen_done),
      .row_valid  (row_valid),
      .row_idx    (row_idx),
      .done       (done),
      .last_cycle (run_last)
   );

   assign A     = a_q;
   assign B     = b_q;
   assign error = err_q;

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Bench for gemm_operand_loader: frame-level reference model checked every cycle
// plus literal spot checks on bank contents and run timing.
module tb_gemm_operand_loader;
   import gemm_pkg::*;

   localparam int M = 2, N = 4, K = 4, DW = 8;
   localparam int RUN_LEN = M * DW;
`ifdef GEMM_LOADER_BIAS_EN
   localparam int FL = M * K + K * N + N;
   localparam bit HAS_BIAS = 1'b1;
`else
   localparam int FL = M * K + K * N;
   localparam bit HAS_BIAS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s_valid = 1'b0, s_last = 1'b0;
   logic [7:0] s_data = '0;
   logic s_ready, bias_en, gen_done, row_valid, done, error;
   logic [0:0] row_idx;
   logic [M-1:0][K-1:0][7:0] A;
   logic [K-1:0][N-1:0][7:0] B;
   logic [N-1:0][7:0] bias;

   gemm_operand_loader dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .A(A), .B(B), .bias(bias), .bias_en(bias_en), .gen_done(gen_done),
      .row_valid(row_valid), .row_idx(row_idx), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int nVectors = 0;
   int nMiscompares = 0;

   // Reference model: frame position, remaining run cycles, expected banks.
   int ma [M][K];
   int mb [K][N];
   int mbias [N];
   int wIdx, runLeft;
   bit doneE, errE;

   typedef struct { int pos; int idx; } rv_t;
   rv_t rvLog [$];
   int gdCount, doneCount;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         foreach (ma[r, c]) ma[r][c] = 0;
         foreach (mb[r, c]) mb[r][c] = 0;
         foreach (mbias[i]) mbias[i] = 0;
         wIdx = 0; runLeft = 0; doneE = 0; errE = 0;
      end else begin
         doneE = 0;
         if (runLeft > 0) begin
            runLeft--;
            if (runLeft == 0) doneE = 1;
         end else if (s_valid) begin
            int v;
            v = int'($signed(s_data));
            if (wIdx == 0) errE = 0;
            if (wIdx < M * K) ma[wIdx / K][wIdx % K] = v;
            else if (wIdx < M * K + K * N) mb[(wIdx - M * K) / N][(wIdx - M * K) % N] = v;
            else mbias[wIdx - M * K - K * N] = v;
            if (s_last != (wIdx == FL - 1)) begin
               errE = 1; wIdx = 0;
            end else if (wIdx == FL - 1) begin
               runLeft = RUN_LEN; wIdx = 0;
            end else begin
               wIdx++;
            end
         end
      end
   end

   // Every-cycle comparison against the model, plus run-shape bookkeeping.
   always @(negedge clk) begin
      int runCyc;
      runCyc = RUN_LEN - runLeft + 1;
      checkOutput("s_ready", int'(s_ready), int'(rst && runLeft == 0));
      checkOutput("gen_done", int'(gen_done), int'(runLeft > 0));
      checkOutput("bias_en", int'(bias_en), int'(HAS_BIAS && runLeft > 0));
      checkOutput("row_valid", int'(row_valid), int'(runLeft > 0 && runCyc % DW == 0));
      if (runLeft > 0 && runCyc % DW == 0)
         checkOutput("row_idx", int'(row_idx), (runCyc - 1) / DW);
      checkOutput("done", int'(done), int'(doneE));
      checkOutput("error", int'(error), int'(errE));
      foreach (ma[r, c]) checkOutput($sformatf("A[%0d][%0d]", r, c), int'($signed(A[r][c])), ma[r][c]);
      foreach (mb[r, c]) checkOutput($sformatf("B[%0d][%0d]", r, c), int'($signed(B[r][c])), mb[r][c]);
      foreach (mbias[i]) checkOutput($sformatf("bias[%0d]", i), int'($signed(bias[i])), mbias[i]);
      if (gen_done) begin
         gdCount++;
         if (row_valid) rvLog.push_back('{gdCount, int'(row_idx)});
      end
      if (done) doneCount++;
   end

   task automatic applyStimulus(input logic [7:0] data, input logic last);
      int k;
      s_valid = 1'b1; s_data = data; s_last = last;
      k = 0;
      while (!s_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) checkOutput("ready_timeout", 0, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic sendFrame(input int nWords, input int lastAt, input int gap, input bit ffFirst);
      gdCount = 0; doneCount = 0; rvLog.delete();
      for (int w = 1; w <= nWords; w++) begin
         applyStimulus((ffFirst && w == 1) ? 8'hFF : 8'(w), w == lastAt);
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkRunShape();
      checkOutput("gen_done_cycles", gdCount, RUN_LEN);
      checkOutput("done_count", doneCount, 1);
      checkOutput("row_valid_count", rvLog.size(), 2);
      if (rvLog.size() == 2) begin
         checkOutput("row0_pos", rvLog[0].pos, 8);
         checkOutput("row0_idx", rvLog[0].idx, 0);
         checkOutput("row1_pos", rvLog[1].pos, 16);
         checkOutput("row1_idx", rvLog[1].idx, 1);
      end
   endtask

   initial begin
      #7;
      checkOutput("rst_s_ready", int'(s_ready), 0);
      checkOutput("rst_gen_done", int'(gen_done), 0);
      checkOutput("rst_row_idx", int'(row_idx), 0);
      checkOutput("rst_A", int'(A[0][0]), 0);
      #5 rst = 1'b1;
      idle(1);

      $display("[TB] clean frame");
      sendFrame(FL, FL, 0, 1'b0);
      idle(RUN_LEN + 4);
      checkOutput("A00", int'($signed(A[0][0])), 1);
      checkOutput("A13", int'($signed(A[1][3])), 8);
      checkOutput("B00", int'($signed(B[0][0])), 9);
      checkOutput("B33", int'($signed(B[3][3])), 24);
      checkOutput("bias3", int'($signed(bias[3])), HAS_BIAS ? 28 : 0);
      checkRunShape();

      $display("[TB] frame with gaps");
      sendFrame(FL, FL, 2, 1'b0);
      idle(RUN_LEN + 4);
      checkOutput("gap_A13", int'($signed(A[1][3])), 8);
      checkOutput("gap_B33", int'($signed(B[3][3])), 24);
      checkRunShape();

      $display("[TB] early s_last");
      sendFrame(10, 10, 0, 1'b0);
      checkOutput("early_error", int'(error), 1);
      idle(RUN_LEN + 4);
      checkOutput("early_no_run", gdCount, 0);
      applyStimulus(8'd1, 1'b0);
      checkOutput("error_cleared", int'(error), 0);
      for (int w = 2; w <= FL; w++) applyStimulus(8'(w), w == FL);
      idle(RUN_LEN + 4);
      checkOutput("recover_run", gdCount, RUN_LEN);

      $display("[TB] missing s_last");
      sendFrame(FL, 0, 0, 1'b0);
      checkOutput("nolast_error", int'(error), 1);
      idle(RUN_LEN + 4);
      checkOutput("nolast_no_run", gdCount, 0);

      $display("[TB] reset mid-run");
      sendFrame(FL, FL, 0, 1'b0);
      begin
         int k;
         k = 0;
         while (gdCount < 5 && k < 100) begin @(negedge clk); k++; end
         if (k >= 100) checkOutput("run_timeout", 0, 1);
      end
      #1 rst = 1'b0;
      #1;
      checkOutput("async_gen_done", int'(gen_done), 0);
      checkOutput("async_A00", int'(A[0][0]), 0);
      checkOutput("async_B33", int'(B[3][3]), 0);
      checkOutput("async_bias_en", int'(bias_en), 0);
      checkOutput("async_s_ready", int'(s_ready), 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("release_s_ready", int'(s_ready), 1);
      doneCount = 0;
      idle(RUN_LEN + 4);
      checkOutput("release_no_done", doneCount, 0);

      $display("[TB] negative element");
      sendFrame(FL, FL, 0, 1'b1);
      idle(RUN_LEN + 4);
      checkOutput("A00_neg", int'($signed(A[0][0])), -1);
      checkRunShape();

      $display("[TB] == %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
